main_reg_op: RTL and testbench

4-bit accumulator-style register with a small operation set. On each rising clock edge with `load` high, it replaces its contents with a function of the current value and `reg_in`, selected by `s`. With `load` low it holds. It is a self-contained leaf datapath block whose `reg_out` feeds downstream logic directly.

---
 rtl/main_reg_op_pkg.sv | 14 +
 rtl/main_reg_op_if.sv | 25 ++
 rtl/main_reg_op_alu.sv | 24 ++
 rtl/main_reg_op.sv | 39 +++
 tb/tb_main_reg_op.sv | 111 +++++++++++
 5 files changed

// File: rtl/main_reg_op_pkg.sv
// main_reg_op_pkg: shared width and op-code constants
// for the 4-bit operation register and its ALU.
package main_reg_op_pkg;

    localparam int WIDTH = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/main_reg_op_if.sv
// main_reg_op_if: command/data bundle of the operation register.
// load/s/reg_in flow master->slave, reg_out flows slave->master.
interface main_reg_op_if;
    import main_reg_op_pkg::*;

    logic       load;
    logic [1:0] s;
    word_t      reg_in;
    word_t      reg_out;

    modport master (
        output load,
        output s,
        output reg_in,
        input  reg_out
    );

    modport slave (
        input  load,
        input  s,
        input  reg_in,
        output reg_out
    );

endinterface

// File: rtl/main_reg_op_alu.sv
// main_reg_op_alu: combinational next-value unit.
// Ports: r_i (current value), b_i (operand), op_i (select), y_o (result).
module main_reg_op_alu
    import main_reg_op_pkg::*;
(
    input  word_t      r_i,
    input  word_t      b_i,
    input  logic [1:0] op_i,
    output word_t      y_o
);

    // 4-bit results: carry/borrow fall off the top naturally.
    always_comb begin
        y_o = b_i;
        unique case (op_i)
            OP_LOAD: y_o = b_i;
            OP_ADD:  y_o = r_i + b_i;
            OP_SUB:  y_o = r_i - b_i;
            OP_XOR:  y_o = r_i ^ b_i;
            default: y_o = b_i;
        endcase
    end

endmodule

// File: rtl/main_reg_op.sv
// main_reg_op: 4-bit register updated by LOAD/ADD/SUB/XOR when load=1.
// Ports: clk, reset (async active-low), bus (slave: load, s, reg_in, reg_out).
module main_reg_op
    import main_reg_op_pkg::*;
(
    input logic           clk,
    input logic           reset,
    main_reg_op_if.slave  bus
);

    word_t r_q;
    word_t r_d;
    word_t alu_y;

    main_reg_op_alu u_alu (
        .r_i  (r_q),
        .b_i  (bus.reg_in),
        .op_i (bus.s),
        .y_o  (alu_y)
    );

    always_comb begin
        r_d = r_q;
        if (bus.load) begin
            r_d = alu_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign bus.reg_out = r_q;

endmodule

// File: tb/tb_main_reg_op.sv
// tb_main_reg_op: directed checks of main_reg_op with
// hand-computed expected register contents.
module tb_main_reg_op;
    import main_reg_op_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    main_reg_op_if bus ();

    main_reg_op dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp);
        checks++;
        assert (bus.reg_out === exp)
        else begin
            errors++;
            $error("FAIL %s: reg_out=%h expected=%h", tag, bus.reg_out, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic l, input logic [1:0] op,
                        input logic [3:0] d, input logic [3:0] exp,
                        input string tag);
        bus.load   = l;
        bus.s      = op;
        bus.reg_in = d;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.load   = 1'b0;
        bus.s      = OP_LOAD;
        bus.reg_in = 4'h0;

        #2;
        check("reset_initial", 4'h0);
        @(negedge clk);
        reset = 1'b1;

        // Async clear mid-cycle, no clock edge needed.
        step(1'b1, OP_LOAD, 4'h9, 4'h9, "load_9");
        #2;
        reset = 1'b0;
        #1;
        check("async_clear", 4'h0);
        step(1'b1, OP_LOAD, 4'h5, 4'h0, "held_in_reset");
        #2;
        reset = 1'b1;

        // Load and hold.
        step(1'b1, OP_LOAD, 4'h6, 4'h6, "load_6");
        step(1'b0, OP_XOR, 4'h7, 4'h6, "hold_1");
        step(1'b0, OP_XOR, 4'h7, 4'h6, "hold_2");
        step(1'b0, OP_XOR, 4'h7, 4'h6, "hold_3");

        // Add / subtract with wrap.
        step(1'b1, OP_LOAD, 4'h9, 4'h9, "load_9b");
        step(1'b1, OP_ADD, 4'hA, 4'h3, "add_wrap");
        step(1'b1, OP_LOAD, 4'h8, 4'h8, "load_8");
        step(1'b1, OP_SUB, 4'hB, 4'hD, "sub_wrap");

        // Chained ops from zero.
        step(1'b1, OP_LOAD, 4'h0, 4'h0, "load_0");
        step(1'b1, OP_LOAD, 4'h9, 4'h9, "chain_load");
        step(1'b1, OP_ADD, 4'hA, 4'h3, "chain_add");
        step(1'b1, OP_SUB, 4'hB, 4'h8, "chain_sub");
        step(1'b1, OP_XOR, 4'hC, 4'h4, "chain_xor");

        // Wrap boundaries.
        step(1'b1, OP_LOAD, 4'hF, 4'hF, "load_f");
        step(1'b1, OP_ADD, 4'h1, 4'h0, "f_add_1");
        step(1'b1, OP_SUB, 4'h1, 4'hF, "0_sub_1");
        step(1'b1, OP_XOR, 4'hF, 4'h0, "x_xor_x");
        step(1'b1, OP_XOR, 4'h5, 4'h5, "xor_5");

        // Clear while an ADD is pending, then the ADD applies from zero.
        step(1'b1, OP_LOAD, 4'hC, 4'hC, "load_c");
        bus.load   = 1'b1;
        bus.s      = OP_ADD;
        bus.reg_in = 4'h1;
        #1;
        reset = 1'b0;
        #1;
        check("pending_clear", 4'h0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("add_after_release", 4'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
